// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Holds the FSM state enum, the default requester count and word widths.
package seg7_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OPEN
    } state_e;

endpackage

// File: rtl/seg7_display_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first requester after last_i.
// Ports: req_i (request vector), last_i (previous winner), idx_o, found_o.
module rr_pick
    import seg7_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    int d;
    int best;

    // Distance from last_i going forward with wrap; the smallest wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        d       = 0;
        best    = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (i > int'(last_i)) begin
                d = i - int'(last_i) - 1;
            end else begin
                d = i + NREQ - int'(last_i) - 1;
            end
            if (req_i[i] && (d < best)) begin
                best    = d;
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Time-sliced arbiter sharing one 8-digit display among NREQ requesters.
// Ports: clk, reset, req/data in; grant, owner, busy, x_l, x_h, blank out.
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data,
    output logic [NREQ-1:0]        grant,
    output logic [2:0]             owner,
    output logic                   busy,
    output logic [15:0]            x_l,
    output logic [15:0]            x_h,
    output logic                   blank
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]  x_q, x_d;

    logic [NREQ-1:0]    pick_req;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [NREQ-1:0]    pick_oh;
    logic               own_req;
    logic [DATA_W-1:0]  sel;

    // Masking the current owner lets one picker serve IDLE and OPEN:
    // in IDLE grant_q is zero, in OPEN last_q equals the owner.
    assign pick_req = req & ~grant_q;
    assign pick_oh  = NREQ'(1) << pick_idx;
    assign own_req  = |(req & grant_q);

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (pick_req),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                sel = data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        last_d  = last_q;
        x_d     = busy_q ? sel : x_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    last_d  = pick_idx;
                end
            end
            HOLD: begin
                // Owner drop wins over tenure expiry.
                if (!own_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = OPEN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OPEN: begin
                // Counter stays saturated at CNT_LAST here.
                if (!own_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (pick_found) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= IDX_W'(NREQ - 1);
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            x_q     <= x_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign blank = ~busy_q;
    assign x_l   = x_q[15:0];
    assign x_h   = x_q[31:16];

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Scoreboard bench for seg7_display_arbiter with NREQ=4, HOLD_CYCLES=8.
// Expected outputs come from a cycle model pushed before each clock edge.
module tb_seg7_display_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 8;

    typedef struct {
        logic [3:0]  g;
        logic        busy;
        logic [2:0]  own;
        logic [31:0] x;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   grant;
    logic [2:0]   owner;
    logic         busy;
    logic [15:0]  x_l;
    logic [15:0]  x_h;
    logic         blank;

    exp_t       sb[$];
    logic [3:0] ord_q[$];
    logic [3:0] prev_g;

    int n_chk  = 0;
    int n_pass = 0;

    int          m_own;
    int          m_last;
    int          m_age;
    logic [31:0] m_x;

    seg7_display_arbiter #(
        .NREQ        (NREQ),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .data  (data),
        .grant (grant),
        .owner (owner),
        .busy  (busy),
        .x_l   (x_l),
        .x_h   (x_h),
        .blank (blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int excl);
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (m_last + k) % NREQ;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        int p;
        if (reset) begin
            m_own  = -1;
            m_last = NREQ - 1;
            m_age  = 0;
            m_x    = '0;
        end else begin
            if (m_own >= 0) m_x = data[m_own*32 +: 32];
            if (m_own >= 0 && !req[m_own]) begin
                m_own = -1;
            end else if (m_own < 0) begin
                p = pick(req, -1);
                if (p >= 0) begin
                    m_own  = p;
                    m_last = p;
                    m_age  = 0;
                end
            end else if (m_age >= HOLD) begin
                p = pick(req, m_own);
                if (p >= 0) begin
                    m_own  = p;
                    m_last = p;
                    m_age  = 0;
                end else begin
                    m_age++;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.busy = (m_own >= 0);
        e.g    = e.busy ? (4'b0001 << m_own) : 4'b0000;
        e.own  = e.busy ? 3'(m_own) : 3'd0;
        e.x    = m_x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("grant", 32'(grant), 32'(e.g));
        check("busy", 32'(busy), 32'(e.busy));
        check("blank", 32'(blank), 32'(!e.busy));
        check("x", {x_h, x_l}, e.x);
        if (e.busy) check("owner", 32'(owner), 32'(e.own));
        check("onehot", 32'($countones(grant) <= 1), 32'd1);
        check("busy_or", 32'(busy), 32'(|grant));
        if (grant != prev_g && grant != 4'b0 && ord_q.size() > 0)
            check("order", 32'(grant), 32'(ord_q.pop_front()));
        prev_g = grant;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset  = 1'b1;
        req    = '0;
        data   = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        prev_g = '0;
        m_own  = -1;
        m_last = NREQ - 1;
        m_age  = 0;
        m_x    = '0;

        // reset state
        run(2);
        reset = 1'b0;
        run(2);

        // single request, held indefinitely
        data[64 +: 32] = 32'h1234_5678;
        req = 4'b0100;
        run(2);
        check("x_h_single", 32'(x_h), 32'h1234);
        check("x_l_single", 32'(x_l), 32'h5678);
        run(20);
        req = 4'b0000;
        run(3);

        // contention from a fresh reset
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        data[64 +: 32] = 32'hCCCC_0002;
        ord_q.push_back(4'b0001);
        ord_q.push_back(4'b0010);
        ord_q.push_back(4'b1000);
        ord_q.push_back(4'b0001);
        req = 4'b1011;
        run(40);
        check("order_done", 32'(ord_q.size()), 32'd0);
        req = 4'b0000;
        run(2);

        // early drop by owner 1 while requester 3 waits
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        req = 4'b1010;
        run(4);
        req = 4'b1000;
        run(3);
        check("drop_owner", 32'(owner), 32'd3);
        req = 4'b0000;
        run(2);

        // mid-tenure reset restarts priority at requester 0
        req = 4'b1110;
        run(5);
        req = 4'b1111;
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(3);
        check("rst_next_owner", 32'(grant), 32'b0001);
        req = 4'b0000;
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
